// File: rtl/text_fetch_initiator.sv
// Sequential instruction fetch initiator with a credit-gated instruction/PC FIFO and redirect flush.
// Define FETCH_STATS_EN to enable the wait-cycle and discarded-response counters.
`ifndef TEXT_BEGIN
`define TEXT_BEGIN 32'h0040_0000
`endif

module text_fetch_initiator #(
    parameter logic [31:0] RESET_PC   = `TEXT_BEGIN,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        bus_read_enable,
    output logic [31:0] bus_address,
    input  logic [31:0] bus_read_data,
    input  logic        bus_wait_req,
    input  logic        bus_valid,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        out_ready,
    output logic [31:0] stat_wait_cycles,
    output logic [31:0] stat_discarded
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [63:0]   mem_q [FIFO_DEPTH];

    logic          accept, push, pop;
    logic [CW-1:0] in_use;
    logic [CW-1:0] valid_ext;
    logic [31:0]   redirect_aligned;

    assign in_use           = outstanding_q + count_q;
    assign valid_ext        = CW'(bus_valid);
    assign redirect_aligned = redirect_pc & ~32'd3;
    assign bus_address      = fetch_pc_q;
    assign out_pc           = mem_q[rd_ptr_q][63:32];
    assign out_inst         = mem_q[rd_ptr_q][31:0];

    always_comb begin
        // Credit covers both in-flight reads and buffered entries, so every accepted read has a slot.
        bus_read_enable = !reset && !redirect && (in_use < DEPTH_C);
        accept          = bus_read_enable && !bus_wait_req;
        out_valid       = !reset && (count_q != '0);
        pop             = out_valid && out_ready && !redirect;
        push            = 1'b0;
        fetch_pc_d      = fetch_pc_q;
        resp_pc_d       = resp_pc_q;
        outstanding_d   = outstanding_q;
        discard_d       = discard_q;
        count_d         = count_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        if (redirect) begin
            fetch_pc_d    = redirect_aligned;
            resp_pc_d     = redirect_aligned;
            outstanding_d = outstanding_q - valid_ext;
            discard_d     = outstanding_q - valid_ext;
            count_d       = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            outstanding_d = outstanding_q + CW'(accept) - valid_ext;
            if (bus_valid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    push      = !reset;
                    resp_pc_d = resp_pc_q + 32'd4;
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {resp_pc_q, bus_read_data};
        end
    end

    push_when_full: assert property (@(posedge clock) disable iff (reset)
        !(push && (count_q == DEPTH_C)));

`ifdef FETCH_STATS_EN
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic [31:0] disc_cnt_q, disc_cnt_d;
    logic        drop;

    // A response in a redirect cycle is dropped even when discard is zero.
    assign drop = bus_valid && (redirect || (discard_q != '0));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        disc_cnt_d = disc_cnt_q;
        if (bus_read_enable && bus_wait_req && (wait_cnt_q != '1)) begin
            wait_cnt_d = wait_cnt_q + 32'd1;
        end
        if (drop && (disc_cnt_q != '1)) begin
            disc_cnt_d = disc_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q <= '0;
            disc_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            disc_cnt_q <= disc_cnt_d;
        end
    end

    assign stat_wait_cycles = wait_cnt_q;
    assign stat_discarded   = disc_cnt_q;
`else
    assign stat_wait_cycles = '0;
    assign stat_discarded   = '0;
`endif

endmodule

// File: tb/tb_text_fetch_initiator.sv
// Randomized scoreboard bench for text_fetch_initiator with an in-order variable-latency responder.
module tb_text_fetch_initiator;
    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam int          DEPTH  = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        bus_read_enable;
    logic [31:0] bus_address;
    logic [31:0] bus_read_data;
    logic        bus_wait_req;
    logic        bus_valid;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;
    logic [31:0] stat_wait_cycles;
    logic [31:0] stat_discarded;

    text_fetch_initiator #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .bus_read_enable(bus_read_enable), .bus_address(bus_address),
        .bus_read_data(bus_read_data), .bus_wait_req(bus_wait_req), .bus_valid(bus_valid),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready),
        .stat_wait_cycles(stat_wait_cycles), .stat_discarded(stat_discarded)
    );

    always #5 clock = ~clock;

    typedef struct packed { logic [31:0] addr; logic [31:0] due; } req_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;

    req_t resp_q[$];
    ent_t exp_q[$];

    int unsigned cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    int          pops = 0;

    // Stimulus knobs.
    int unsigned lat_min = 1, lat_max = 1, valid_pct = 100, wait_pct = 0, ready_pct = 100;
    int unsigned redir_pct = 0, rst_pm = 0;
    bit          hold_reset = 1'b1, f_reset = 1'b0, f_redir = 1'b0, f_wait = 1'b0;
    logic [31:0] f_pc = '0;

    // Reference model state: counts of reads in flight, reads to drop, buffered entries.
    logic [31:0] m_fetch, m_next, m_wait, m_drop;
    int          m_outst, m_disc, m_fifo;
    bit          m_en, m_pop;
    ent_t        m_ent;

    function automatic logic [31:0] img(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            cyc++;
            reset       = hold_reset || f_reset || ($urandom_range(999) < rst_pm);
            f_reset     = 1'b0;
            redirect    = !reset && (f_redir || ($urandom_range(99) < redir_pct));
            redirect_pc = f_redir ? f_pc : (RST_PC + ($urandom_range(511) << 2)) | $urandom_range(3);
            f_redir     = 1'b0;
            out_ready   = ($urandom_range(99) < ready_pct);
            bus_wait_req = f_wait || ($urandom_range(99) < wait_pct);
            bus_valid   = 1'b0;
            bus_read_data = $urandom;
            if (!reset && resp_q.size() > 0 && resp_q[0].due <= cyc && $urandom_range(99) < valid_pct) begin
                bus_valid     = 1'b1;
                bus_read_data = img(resp_q[0].addr);
            end
        end
    endtask

    // Reference model: protocol rules applied to counts and queues, updated once per cycle.
    initial begin
        forever begin
            @(negedge clock);
            #1;
            if (reset) begin
                check("rst_read_enable", 32'(bus_read_enable), 32'd0);
                check("rst_out_valid", 32'(out_valid), 32'd0);
                m_fetch = RST_PC; m_next = RST_PC; m_outst = 0; m_disc = 0; m_fifo = 0;
                m_wait = '0; m_drop = '0;
                exp_q.delete();
                resp_q.delete();
            end else begin
                m_en = !redirect && (m_outst + m_fifo < DEPTH);
                check("read_enable", 32'(bus_read_enable), 32'(m_en));
                if (m_en) check("bus_address", bus_address, m_fetch);
                check("out_valid", 32'(out_valid), 32'(m_fifo > 0));
`ifdef FETCH_STATS_EN
                check("stat_wait_cycles", stat_wait_cycles, m_wait);
                check("stat_discarded", stat_discarded, m_drop);
`else
                check("stat_wait_cycles", stat_wait_cycles, 32'd0);
                check("stat_discarded", stat_discarded, 32'd0);
`endif
                if (bus_valid && resp_q.size() > 0) void'(resp_q.pop_front());
                if (m_en && bus_wait_req) m_wait = m_wait + 32'd1;
                if (redirect) begin
                    if (bus_valid) begin
                        m_drop  = m_drop + 32'd1;
                        m_outst = m_outst - 1;
                    end
                    m_disc  = m_outst;
                    m_fifo  = 0;
                    exp_q.delete();
                    m_fetch = redirect_pc & ~32'd3;
                    m_next  = m_fetch;
                end else begin
                    m_pop = out_ready && (m_fifo > 0);
                    if (bus_valid) begin
                        m_outst = m_outst - 1;
                        if (m_disc > 0) begin
                            m_disc = m_disc - 1;
                            m_drop = m_drop + 32'd1;
                        end else begin
                            m_fifo = m_fifo + 1;
                            m_ent.pc = m_next;
                            m_ent.inst = img(m_next);
                            exp_q.push_back(m_ent);
                            m_next = m_next + 32'd4;
                        end
                    end
                    if (m_pop) m_fifo = m_fifo - 1;
                    if (m_en && !bus_wait_req) begin
                        resp_q.push_back({m_fetch, cyc + $urandom_range(lat_max, lat_min)});
                        m_fetch = m_fetch + 32'd4;
                        m_outst = m_outst + 1;
                    end
                end
            end
        end
    end

    // Monitor: every consumer pop is compared against the expected stream.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && out_valid && out_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL pop_unexpected: got pc %h expected no entry (cycle %0d)", out_pc, cyc);
                end else begin
                    m_ent = exp_q.pop_front();
                    check("out_pc", out_pc, m_ent.pc);
                    check("out_inst", out_inst, m_ent.inst);
                    pops++;
                end
            end
        end
    end

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        bus_wait_req = 1'b0; bus_valid = 1'b0; bus_read_data = '0;
        tick(3);
        hold_reset = 1'b0;
        lat_min = 5; lat_max = 5;
        tick(40);
        check("progress_latency5", 32'(pops >= 5), 32'd1);
        ready_pct = 0; lat_min = 1; lat_max = 1;
        tick(20);
        ready_pct = 100;
        tick(20);
        f_wait = 1'b1;
        tick(10);
        f_wait = 1'b0;
        tick(10);
        lat_min = 4; lat_max = 6;
        tick(8);
        f_redir = 1'b1; f_pc = 32'h0040_0103;
        tick(1);
        tick(30);
        f_redir = 1'b1; f_pc = 32'hFFFF_FFF4;
        tick(1);
        tick(20);
        f_redir = 1'b1; f_pc = 32'h0040_0200;
        tick(1);
        f_redir = 1'b1; f_pc = 32'h0040_0300;
        tick(1);
        tick(20);
        lat_min = 3; lat_max = 3;
        tick(10);
        f_reset = 1'b1;
        tick(1);
        tick(20);
        lat_min = 1; lat_max = 6; valid_pct = 70; wait_pct = 30; ready_pct = 70;
        redir_pct = 3; rst_pm = 3;
        tick(3000);
        valid_pct = 100; wait_pct = 0; ready_pct = 100; redir_pct = 0; rst_pm = 0;
        tick(50);
        check("progress_total", 32'(pops >= 200), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
